// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle RV32I control FSM
//
// Purpose: state enum, supported opcodes and the select/operation encodings
//          driven onto the shared datapath by multicycle_ctrl.
// Ports:   none (package).

package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } mc_state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // result_src
  localparam logic [1:0] RES_ALU_LATCH = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALU_OUT   = 2'b10;

  // alu_src_a
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  // alu_src_b
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // alu_op
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // imm_src
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_imm_src_dec.sv
// rtl/multicycle_ctrl_imm_src_dec.sv - opcode to immediate-format select decoder
//
// Purpose: combinational decode of the instruction opcode into the immediate
//          generator format select; valid in every FSM state.
// Ports:   op      in  7  opcode field of the instruction register
//          imm_src out 2  immediate format (I/S/B/J)

module imm_src_dec
  import mc_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control FSM for the multicycle RV32I core
//
// Purpose: sequences the shared datapath through fetch/decode/execute/memory/
//          writeback for lw, sw, R-type, I-type ALU, beq and jal; stalls on
//          mem_ready and traps (sticky illegal_op) on unsupported opcodes.
// Ports:   clk, reset (async, active-high) ; op[6:0], zero, mem_ready in
//          pc_write, adr_src, mem_write, ir_write, reg_write     out enables/selects
//          result_src, alu_src_a, alu_src_b, alu_op, imm_src    out 2-bit selects
//          illegal_op                                           out sticky trap flag

module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter bit RESET_TRAP_CLR = 1'b1  // only 1 is supported
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_op
);

  mc_state_t r_state;
  mc_state_t w_next;
  logic      r_illegal_op;

  logic       w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
  logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_illegal_op <= !RESET_TRAP_CLR;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_next == S_TRAP) begin
        r_illegal_op <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = RES_ALU_LATCH;
    w_alu_src_a  = SRCA_PC;
    w_alu_src_b  = SRCB_RS2;
    w_alu_op     = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        // PC+4 is computed and loaded in the same cycle the fetch completes
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALU_OUT;
        w_ir_write   = mem_ready;
        w_pc_write   = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target from the old PC
        w_alu_src_a = SRCA_OLD_PC;
        w_alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_src_b = SRCB_IMM;
        w_next      = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = RES_RDATA;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_op    = ALUOP_FUNCT;
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a = SRCA_RS1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = ALUOP_FUNCT;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        // target already sits in the ALU latch from DECODE
        w_alu_src_a = SRCA_RS1;
        w_alu_op    = ALUOP_SUB;
        w_pc_write  = zero;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        // ALU latch holds the target; ALU forms old PC + 4 as the link value
        w_alu_src_a = SRCA_OLD_PC;
        w_alu_src_b = SRCB_FOUR;
        w_pc_write  = 1'b1;
        w_next      = S_ALUWB;
      end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  imm_src_dec u_imm_src_dec (
    .op      (op),
    .imm_src (imm_src)
  );

  // write enables are gated so nothing commits while reset is held
  assign pc_write   = w_pc_write  & ~reset;
  assign ir_write   = w_ir_write  & ~reset;
  assign mem_write  = w_mem_write & ~reset;
  assign reg_write  = w_reg_write & ~reset;
  assign adr_src    = w_adr_src;
  assign result_src = w_result_src;
  assign alu_src_a  = w_alu_src_a;
  assign alu_src_b  = w_alu_src_b;
  assign alu_op     = w_alu_op;
  assign illegal_op = r_illegal_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl

module tb_multicycle_ctrl;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [6:0] op;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

  multicycle_ctrl #(.RESET_TRAP_CLR(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  logic [15:0] q_exp[$];
  string       q_ph[$];
  int          total = 0;
  int          bad = 0;
  logic        ill_m = 1'b0;
  logic [6:0]  cur_op = 7'd0;

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // expected outputs for one cycle spent in the named step
  function automatic logic [15:0] expect_vec(string ph, logic mr, logic z,
                                              logic rst, logic [6:0] o, logic ill);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, a, b, alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; rs = 0; a = 0; b = 0; alu = 0;
    if (ph == "F")        begin rs = 2; b = 2; pcw = mr; irw = mr; end
    else if (ph == "D")   begin a = 1; b = 1; end
    else if (ph == "MA")  begin a = 2; b = 1; end
    else if (ph == "MR")  begin adr = 1; end
    else if (ph == "MWB") begin rs = 1; rw = 1; end
    else if (ph == "MW")  begin adr = 1; mw = 1; end
    else if (ph == "ER")  begin a = 2; alu = 2; end
    else if (ph == "EI")  begin a = 2; b = 1; alu = 2; end
    else if (ph == "AWB") begin rw = 1; end
    else if (ph == "BEQ") begin a = 2; alu = 1; pcw = z; end
    else if (ph == "JAL") begin a = 1; b = 2; pcw = 1; end
    if (rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
    return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm_of(o), ill};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input string ph, input logic mr, input logic z, input logic rst);
    @(posedge clk);
    #1;
    reset = rst; mem_ready = mr; zero = z; op = cur_op;
    if (rst) ill_m = 1'b0;
    else if (ph == "T") ill_m = 1'b1;
    q_exp.push_back(expect_vec(ph, mr, z, rst, cur_op, ill_m));
    q_ph.push_back(ph);
  endtask

  // one instruction from its first FETCH cycle to its last step
  task automatic run_instr(input logic [6:0] o, input int fst, input int mst,
                           input logic z, input int tcyc);
    cur_op = o;
    for (int i = 0; i < fst; i++) cyc("F", 1'b0, rb(), 1'b0);
    cyc("F", 1'b1, rb(), 1'b0);
    cyc("D", rb(), rb(), 1'b0);
    case (o)
      LW: begin
        cyc("MA", rb(), rb(), 1'b0);
        for (int i = 0; i < mst; i++) cyc("MR", 1'b0, rb(), 1'b0);
        cyc("MR", 1'b1, rb(), 1'b0);
        cyc("MWB", rb(), rb(), 1'b0);
      end
      SW: begin
        cyc("MA", rb(), rb(), 1'b0);
        for (int i = 0; i < mst; i++) cyc("MW", 1'b0, rb(), 1'b0);
        cyc("MW", 1'b1, rb(), 1'b0);
      end
      RT: begin cyc("ER", rb(), rb(), 1'b0); cyc("AWB", rb(), rb(), 1'b0); end
      IT: begin cyc("EI", rb(), rb(), 1'b0); cyc("AWB", rb(), rb(), 1'b0); end
      BQ: cyc("BEQ", rb(), z, 1'b0);
      JL: begin cyc("JAL", rb(), rb(), 1'b0); cyc("AWB", rb(), rb(), 1'b0); end
      default: begin
        for (int i = 0; i < tcyc; i++) cyc("T", rb(), rb(), 1'b0);
        cyc("F", rb(), rb(), 1'b1);
      end
    endcase
  endtask

  // monitor: every cycle with an outstanding expectation is compared
  initial begin
    logic [15:0] e, act;
    string ph;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e  = q_exp.pop_front();
        ph = q_ph.pop_front();
        act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, illegal_op};
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL step_%s: actual=%b required=%b (pcw adr mw irw rw rs a b alu imm ill)",
                   ph, act, e);
        end
      end
    end
  end

  initial begin
    logic [6:0] ills[3];
    int k;
    ills[0] = 7'b1111111; ills[1] = 7'b0110111; ills[2] = 7'b0000000;
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = 7'd0;

    cyc("F", 1'b1, 1'b0, 1'b1);
    cyc("F", 1'b1, 1'b1, 1'b1);

    run_instr(LW, 0, 0, 1'b0, 0);
    run_instr(SW, 1, 3, 1'b0, 0);
    run_instr(BQ, 0, 0, 1'b1, 0);
    run_instr(BQ, 0, 0, 1'b0, 0);
    run_instr(JL, 0, 0, 1'b0, 0);
    run_instr(RT, 0, 0, 1'b0, 0);
    run_instr(IT, 2, 0, 1'b0, 0);
    run_instr(7'b1111111, 0, 0, 1'b0, 12);

    // reset lands while MEMREAD is stalled
    cur_op = LW;
    cyc("F", 1'b1, 1'b0, 1'b0);
    cyc("D", 1'b0, 1'b0, 1'b0);
    cyc("MA", 1'b0, 1'b0, 1'b0);
    cyc("MR", 1'b0, 1'b0, 1'b0);
    cyc("MR", 1'b0, 1'b0, 1'b0);
    cyc("F", 1'b0, 1'b0, 1'b1);
    cyc("F", 1'b1, 1'b0, 1'b1);
    run_instr(LW, 0, 1, 1'b0, 0);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 12);
      case (k)
        0, 1:   run_instr(LW, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, 0);
        2, 3:   run_instr(SW, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, 0);
        4, 5:   run_instr(RT, $urandom_range(0, 2), 0, 1'b0, 0);
        6, 7:   run_instr(IT, $urandom_range(0, 2), 0, 1'b0, 0);
        8, 9:   run_instr(BQ, $urandom_range(0, 2), 0, rb(), 0);
        10, 11: run_instr(JL, $urandom_range(0, 2), 0, 1'b0, 0);
        default: run_instr(ills[$urandom_range(0, 2)], 0, 0, 1'b0, $urandom_range(2, 5));
      endcase
    end

    @(negedge clk);
    @(negedge clk);
    if (q_exp.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: actual=%0d pending required=0", q_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
